// File: rtl/cache_def.sv
// Shared cache definitions used by the victim cache controller.
//   - Width constants for address, line offset, tag and line data.
//   - vc_assoc_entry_type  : one fully-associative storage line.
//   - vc_lookup_rsp_type   : registered lookup response.
//   - vc_wb_req_type       : one-entry writeback buffer contents.
//   - vc_flush_state_type  : controller FSM states.
//   - vc_line_addr()       : rebuilds a line-aligned address from a tag.
package cache_def;

  localparam int VC_ADDR_W   = 32;
  localparam int VC_OFFSET_W = 4;
  localparam int VC_LINE_W   = 128;
  localparam int VC_TAG_W    = VC_ADDR_W - VC_OFFSET_W;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [VC_TAG_W-1:0]  tag;
    logic [VC_LINE_W-1:0] data;
  } vc_assoc_entry_type;

  typedef struct packed {
    logic                 valid;
    logic                 hit;
    logic                 dirty;
    logic [VC_LINE_W-1:0] data;
  } vc_lookup_rsp_type;

  typedef struct packed {
    logic                 valid;
    logic [VC_ADDR_W-1:0] addr;
    logic [VC_LINE_W-1:0] data;
  } vc_wb_req_type;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FL_SCAN = 2'd1,
    ST_FL_WB   = 2'd2
  } vc_flush_state_type;

  function automatic logic [VC_ADDR_W-1:0] vc_line_addr(input logic [VC_TAG_W-1:0] tag);
    return {tag, {VC_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/adder_32bit.sv
// Plain 32-bit adder shared by the statistics counters.
//   a, b : operands
//   sum  : a + b, wrapping modulo 2^32
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/vc_rr_victim_sel.sv
// Victim slot selector for the fully-associative victim cache.
// Picks the lowest-index invalid slot; when every slot is valid it falls back
// to a round-robin pointer and raises need_replace.
//   clk, rst     : clock, asynchronous active-high reset
//   valid        : per-slot valid bits of the current storage
//   advance      : step the round-robin pointer (a replacement was committed)
//   slot_idx     : chosen slot
//   need_replace : no free slot, slot_idx points at a line to be displaced
module vc_rr_victim_sel #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ENTRIES-1:0] valid,
  input  logic               advance,
  output logic [IDX_W-1:0]   slot_idx,
  output logic               need_replace
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    // Scan downwards so the lowest free index is the last one written.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign need_replace = !free_found;
  assign slot_idx     = free_found ? free_idx : rr_ptr;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance) begin
      // ENTRIES is a power of two, so natural wrap is modulo ENTRIES.
      rr_ptr <= rr_ptr + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vc_assoc_controller.sv
// Fully-associative victim cache controller between L1 and the next level.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   lookup_*            : L1 miss lookup; registered response on rsp_*
//                         (a hit moves the line back to L1 and frees the slot)
//   evict_*             : L1 victim insert; a hit in the same cycle swaps slots
//   wb_*                : one-entry writeback buffer toward memory
//   flush_i/flush_done_o: write back every dirty line, then invalidate all
//   occupancy_o         : registered count of valid lines
//   no_acc/hit/miss/wb_o: wrapping statistics counters
// Tag, address and line widths must match the cache_def storage types.
// Reset during a flush or pending writeback discards the buffered line.
module vc_assoc_controller
  import cache_def::*;
#(
  parameter int ENTRIES  = 4,
  parameter int ADDR_W   = VC_ADDR_W,
  parameter int OFFSET_W = VC_OFFSET_W,
  parameter int LINE_W   = VC_LINE_W,
  parameter int CNT_W    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      lookup_valid_i,
  input  logic [ADDR_W-1:0]         lookup_addr_i,
  output logic                      lookup_ready_o,
  output logic                      rsp_valid_o,
  output logic                      rsp_hit_o,
  output logic [LINE_W-1:0]         rsp_data_o,
  output logic                      rsp_dirty_o,
  input  logic                      evict_valid_i,
  input  logic [ADDR_W-1:0]         evict_addr_i,
  input  logic [LINE_W-1:0]         evict_data_i,
  input  logic                      evict_dirty_i,
  output logic                      evict_ready_o,
  output logic                      wb_valid_o,
  output logic [ADDR_W-1:0]         wb_addr_o,
  output logic [LINE_W-1:0]         wb_data_o,
  input  logic                      wb_ready_i,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic [$clog2(ENTRIES):0]  occupancy_o,
  output logic [CNT_W-1:0]          no_acc_o,
  output logic [CNT_W-1:0]          no_hit_o,
  output logic [CNT_W-1:0]          no_miss_o,
  output logic [CNT_W-1:0]          no_wb_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam int TAG_W = ADDR_W - OFFSET_W;

  vc_flush_state_type state_q, state_d;
  vc_assoc_entry_type entries_q [ENTRIES];
  vc_assoc_entry_type entries_d [ENTRIES];
  vc_wb_req_type      wb_q, wb_d;
  vc_lookup_rsp_type  rsp_q, rsp_d;
  logic [IDX_W-1:0]   scan_idx_q;
  logic               flush_done_q, done_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               scan_wb, scan_clr, scan_adv;

  logic [TAG_W-1:0]   lookup_tag, evict_tag;
  logic               lk_fire, ev_fire, wb_fire;
  logic               hit_found, same_found;
  logic [IDX_W-1:0]   hit_idx, same_idx, tgt_idx;
  logic               new_dirty;
  logic [ENTRIES-1:0] valid_vec;
  logic [IDX_W-1:0]   sel_idx;
  logic               need_replace, rr_advance;

  logic [CNT_W-1:0]   cnt_q   [4];
  logic [CNT_W-1:0]   cnt_sum [4];
  logic [3:0]         cnt_inc;

  logic unused_offset_bits;
  assign unused_offset_bits = ^{lookup_addr_i[OFFSET_W-1:0], evict_addr_i[OFFSET_W-1:0]};

  assign lookup_tag = lookup_addr_i[ADDR_W-1:OFFSET_W];
  assign evict_tag  = evict_addr_i[ADDR_W-1:OFFSET_W];
  assign lk_fire    = lookup_valid_i && lookup_ready_o;
  assign ev_fire    = evict_valid_i && evict_ready_o;
  assign wb_fire    = wb_q.valid && wb_ready_i;

  // Tag match against the pre-update storage for both request ports.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    same_found = 1'b0;
    same_idx   = '0;
    valid_vec  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && entries_q[i].tag == lookup_tag && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
      end
      if (entries_q[i].valid && entries_q[i].tag == evict_tag && !same_found) begin
        same_found = 1'b1;
        same_idx   = IDX_W'(i);
      end
    end
  end

  vc_rr_victim_sel #(.ENTRIES(ENTRIES)) u_victim_sel (
    .clk          (clk_i),
    .rst          (rst_i),
    .valid        (valid_vec),
    .advance      (rr_advance),
    .slot_idx     (sel_idx),
    .need_replace (need_replace)
  );

  // Flush FSM: next state, handshake readiness and scan actions.
  always_comb begin
    state_d        = state_q;
    lookup_ready_o = (state_q == ST_RUN);
    evict_ready_o  = (state_q == ST_RUN) && !wb_q.valid;
    scan_wb        = 1'b0;
    scan_clr       = 1'b0;
    scan_adv       = 1'b0;
    done_d         = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (flush_i) state_d = ST_FL_SCAN;
      end
      ST_FL_SCAN: begin
        if (entries_q[scan_idx_q].valid && entries_q[scan_idx_q].dirty) begin
          // A leftover writeback from normal operation must drain first.
          if (!wb_q.valid) begin
            scan_wb  = 1'b1;
            scan_clr = 1'b1;
            state_d  = ST_FL_WB;
          end
        end else if (entries_q[scan_idx_q].valid) begin
          scan_clr = 1'b1;
        end else if (scan_idx_q == IDX_W'(ENTRIES - 1)) begin
          if (!wb_q.valid) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end
        end else begin
          scan_adv = 1'b1;
        end
      end
      ST_FL_WB: begin
        if (wb_fire) begin
          if (scan_idx_q == IDX_W'(ENTRIES - 1)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
          end else begin
            scan_adv = 1'b1;
            state_d  = ST_FL_SCAN;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Storage, writeback buffer and response next-state.
  always_comb begin
    entries_d  = entries_q;
    wb_d       = wb_q;
    rsp_d      = '0;
    rr_advance = 1'b0;
    tgt_idx    = '0;
    new_dirty  = 1'b0;
    occ_d      = '0;

    if (wb_fire) wb_d.valid = 1'b0;

    if (lk_fire) begin
      rsp_d.valid = 1'b1;
      rsp_d.hit   = hit_found;
      if (hit_found) begin
        rsp_d.dirty = entries_q[hit_idx].dirty;
        rsp_d.data  = entries_q[hit_idx].data;
        // The line returns to L1, which keeps the two levels exclusive.
        entries_d[hit_idx].valid = 1'b0;
      end
    end

    if (ev_fire) begin
      if (lk_fire && hit_found) begin
        tgt_idx   = hit_idx;
        new_dirty = evict_dirty_i;
      end else if (same_found) begin
        tgt_idx   = same_idx;
        new_dirty = evict_dirty_i | entries_q[same_idx].dirty;
      end else begin
        tgt_idx    = sel_idx;
        new_dirty  = evict_dirty_i;
        rr_advance = need_replace;
        // evict_ready_o guarantees the buffer is empty here.
        if (need_replace && entries_q[sel_idx].dirty) begin
          wb_d.valid = 1'b1;
          wb_d.addr  = vc_line_addr(entries_q[sel_idx].tag);
          wb_d.data  = entries_q[sel_idx].data;
        end
      end
      entries_d[tgt_idx] = '{valid: 1'b1, dirty: new_dirty, tag: evict_tag, data: evict_data_i};
    end

    if (scan_wb) begin
      wb_d.valid = 1'b1;
      wb_d.addr  = vc_line_addr(entries_q[scan_idx_q].tag);
      wb_d.data  = entries_q[scan_idx_q].data;
    end
    if (scan_clr) entries_d[scan_idx_q].valid = 1'b0;

    for (int i = 0; i < ENTRIES; i++) occ_d = occ_d + OCC_W'(entries_d[i].valid);
  end

  assign cnt_inc = {wb_fire, lk_fire && !hit_found, lk_fire && hit_found, lk_fire};

  for (genvar g = 0; g < 4; g++) begin : g_cnt
    if (CNT_W == 32) begin : g_add32
      adder_32bit u_add (
        .a   (cnt_q[g]),
        .b   ({31'd0, cnt_inc[g]}),
        .sum (cnt_sum[g])
      );
    end else begin : g_add
      assign cnt_sum[g] = cnt_q[g] + CNT_W'(cnt_inc[g]);
    end
  end

  // NOTE: the storage is a handful of flops, so it is fully reset; a RAM-based
  // array would reset only the valid bits and leave tag/data uninitialised.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      wb_q         <= '0;
      rsp_q        <= '0;
      scan_idx_q   <= '0;
      flush_done_q <= 1'b0;
      occ_q        <= '0;
    end else begin
      entries_q    <= entries_d;
      cnt_q        <= cnt_sum;
      wb_q         <= wb_d;
      rsp_q        <= rsp_d;
      flush_done_q <= done_d;
      occ_q        <= occ_d;
      if (state_q == ST_RUN) scan_idx_q <= '0;
      else if (scan_adv)     scan_idx_q <= scan_idx_q + IDX_W'(1);
    end
  end

  assign rsp_valid_o  = rsp_q.valid;
  assign rsp_hit_o    = rsp_q.hit;
  assign rsp_dirty_o  = rsp_q.dirty;
  assign rsp_data_o   = rsp_q.data;
  assign wb_valid_o   = wb_q.valid;
  assign wb_addr_o    = wb_q.addr;
  assign wb_data_o    = wb_q.data;
  assign flush_done_o = flush_done_q;
  assign occupancy_o  = occ_q;
  assign no_acc_o     = cnt_q[0];
  assign no_hit_o     = cnt_q[1];
  assign no_miss_o    = cnt_q[2];
  assign no_wb_o      = cnt_q[3];

endmodule

// File: tb/tb_vc_assoc_controller.sv
// Self-checking bench for vc_assoc_controller: a table of single-cycle
// vectors followed by hand-written flush and reset-during-writeback sequences.
module tb_vc_assoc_controller;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         lookup_valid_i, evict_valid_i, evict_dirty_i, wb_ready_i, flush_i;
  logic [31:0]  lookup_addr_i, evict_addr_i;
  logic [127:0] evict_data_i;
  logic         lookup_ready_o, rsp_valid_o, rsp_hit_o, rsp_dirty_o, evict_ready_o;
  logic         wb_valid_o, flush_done_o;
  logic [127:0] rsp_data_o, wb_data_o;
  logic [31:0]  wb_addr_o;
  logic [2:0]   occupancy_o;
  logic [31:0]  no_acc_o, no_hit_o, no_miss_o, no_wb_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  vc_assoc_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_addr_i  (lookup_addr_i),
    .lookup_ready_o (lookup_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_hit_o      (rsp_hit_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_dirty_o    (rsp_dirty_o),
    .evict_valid_i  (evict_valid_i),
    .evict_addr_i   (evict_addr_i),
    .evict_data_i   (evict_data_i),
    .evict_dirty_i  (evict_dirty_i),
    .evict_ready_o  (evict_ready_o),
    .wb_valid_o     (wb_valid_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_ready_i     (wb_ready_i),
    .flush_i        (flush_i),
    .flush_done_o   (flush_done_o),
    .occupancy_o    (occupancy_o),
    .no_acc_o       (no_acc_o),
    .no_hit_o       (no_hit_o),
    .no_miss_o      (no_miss_o),
    .no_wb_o        (no_wb_o)
  );

  typedef struct {
    logic         lk_v;
    logic [31:0]  lk_a;
    logic         ev_v;
    logic [31:0]  ev_a;
    logic [127:0] ev_d;
    logic         ev_dirty;
    logic         wb_rdy;
    logic         x_rv;
    logic         x_hit;
    logic         x_dirty;
    logic [127:0] x_data;
    logic [2:0]   x_occ;
    logic         x_wbv;
    logic [31:0]  x_wba;
    logic [127:0] x_wbd;
    logic         x_evr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [127:0] md(input logic [31:0] a);
    return {a, ~a, a ^ 32'h1234_5678, 32'hC0FF_EE00};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic lk_v, input logic [31:0] lk_a, input logic ev_v,
                     input logic [31:0] ev_a, input logic [127:0] ev_d, input logic ev_dirty,
                     input logic wb_rdy, input logic x_rv, input logic x_hit, input logic x_dirty,
                     input logic [127:0] x_data, input logic [2:0] x_occ, input logic x_wbv,
                     input logic [31:0] x_wba, input logic [127:0] x_wbd, input logic x_evr);
    vecs.push_back('{lk_v, lk_a, ev_v, ev_a, ev_d, ev_dirty, wb_rdy,
                     x_rv, x_hit, x_dirty, x_data, x_occ, x_wbv, x_wba, x_wbd, x_evr});
  endtask

  task automatic idle_inputs();
    lookup_valid_i = 1'b0;
    lookup_addr_i  = '0;
    evict_valid_i  = 1'b0;
    evict_addr_i   = '0;
    evict_data_i   = '0;
    evict_dirty_i  = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic ins(input logic [31:0] a, input logic dirty);
    @(negedge clk_i);
    evict_valid_i = 1'b1;
    evict_addr_i  = a;
    evict_data_i  = md(a);
    evict_dirty_i = dirty;
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic lookup_miss(input logic [31:0] a, input string name);
    @(negedge clk_i);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    @(posedge clk_i);
    #1;
    check({name, " rsp_valid"}, rsp_valid_o, 1);
    check({name, " rsp_hit"}, rsp_hit_o, 0);
    idle_inputs();
  endtask

  initial begin
    logic [31:0] wb_addrs[$];
    logic [31:0] a0, a1;
    int done_cnt, lr_bad, wait_cnt, budget, tail;

    idle_inputs();
    wb_ready_i = 1'b0;

    // Vector table: inputs for one cycle, expected outputs after that edge.
    add(0, 0,        1, 'h1000, md('h1000), 0, 0,  0, 0, 0, 0,          1, 0, 0,     0,         1);
    add(1, 'h1008,   0, 0,      0,          0, 0,  1, 1, 0, md('h1000), 0, 0, 0,     0,         1);
    add(1, 'h1000,   0, 0,      0,          0, 0,  1, 0, 0, 0,          0, 0, 0,     0,         1);
    add(0, 0,        1, 'h100,  md('h100),  1, 0,  0, 0, 0, 0,          1, 0, 0,     0,         1);
    add(0, 0,        1, 'h200,  md('h200),  1, 0,  0, 0, 0, 0,          2, 0, 0,     0,         1);
    add(0, 0,        1, 'h300,  md('h300),  1, 0,  0, 0, 0, 0,          3, 0, 0,     0,         1);
    add(0, 0,        1, 'h400,  md('h400),  1, 0,  0, 0, 0, 0,          4, 0, 0,     0,         1);
    add(0, 0,        1, 'h500,  md('h500),  1, 0,  0, 0, 0, 0,          4, 1, 'h100, md('h100), 0);
    add(0, 0,        1, 'h900,  md('h900),  1, 0,  0, 0, 0, 0,          4, 1, 'h100, md('h100), 0);
    add(0, 0,        0, 0,      0,          0, 1,  0, 0, 0, 0,          4, 0, 0,     0,         1);
    add(1, 'h200,    1, 'h600,  md('h600),  1, 0,  1, 1, 1, md('h200),  4, 0, 0,     0,         1);
    add(0, 0,        1, 'h800,  md('h800),  0, 0,  0, 0, 0, 0,          4, 1, 'h600, md('h600), 0);
    add(0, 0,        0, 0,      0,          0, 1,  0, 0, 0, 0,          4, 0, 0,     0,         1);
    add(1, 'h300,    0, 0,      0,          0, 0,  1, 1, 1, md('h300),  3, 0, 0,     0,         1);
    add(0, 0,        1, 'h700,  md('h700),  0, 0,  0, 0, 0, 0,          4, 0, 0,     0,         1);
    add(0, 0,        1, 'h700,  md('h7FF),  1, 0,  0, 0, 0, 0,          4, 0, 0,     0,         1);
    add(1, 'h704,    0, 0,      0,          0, 0,  1, 1, 1, md('h7FF),  3, 0, 0,     0,         1);

    // Reset values while reset is held.
    #12;
    check("reset lookup_ready", lookup_ready_o, 1);
    check("reset evict_ready", evict_ready_o, 1);
    check("reset rsp_valid", rsp_valid_o, 0);
    check("reset wb_valid", wb_valid_o, 0);
    check("reset occupancy", occupancy_o, 0);
    check("reset flush_done", flush_done_o, 0);
    check("reset no_acc", no_acc_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      lookup_valid_i = vecs[i].lk_v;
      lookup_addr_i  = vecs[i].lk_a;
      evict_valid_i  = vecs[i].ev_v;
      evict_addr_i   = vecs[i].ev_a;
      evict_data_i   = vecs[i].ev_d;
      evict_dirty_i  = vecs[i].ev_dirty;
      wb_ready_i     = vecs[i].wb_rdy;
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d rsp_valid", i), rsp_valid_o, vecs[i].x_rv);
      if (vecs[i].x_rv) begin
        check($sformatf("v%0d rsp_hit", i), rsp_hit_o, vecs[i].x_hit);
        check($sformatf("v%0d rsp_dirty", i), rsp_dirty_o, vecs[i].x_dirty);
        check($sformatf("v%0d rsp_data", i), rsp_data_o, vecs[i].x_data);
      end
      check($sformatf("v%0d occupancy", i), occupancy_o, vecs[i].x_occ);
      check($sformatf("v%0d wb_valid", i), wb_valid_o, vecs[i].x_wbv);
      if (vecs[i].x_wbv) begin
        check($sformatf("v%0d wb_addr", i), wb_addr_o, vecs[i].x_wba);
        check($sformatf("v%0d wb_data", i), wb_data_o, vecs[i].x_wbd);
      end
      check($sformatf("v%0d evict_ready", i), evict_ready_o, vecs[i].x_evr);
      idle_inputs();
      wb_ready_i = 1'b0;
    end

    check("cnt no_acc", no_acc_o, 5);
    check("cnt no_hit", no_hit_o, 4);
    check("cnt no_miss", no_miss_o, 1);
    check("cnt no_wb", no_wb_o, 2);

    // Flush: two dirty and two clean lines, memory stalls 3 cycles per line.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    ins('h1100, 1);
    ins('h1200, 0);
    ins('h1300, 1);
    ins('h1400, 0);
    check("flush pre occupancy", occupancy_o, 4);
    @(negedge clk_i);
    flush_i  = 1'b1;
    done_cnt = 0;
    lr_bad   = 0;
    wait_cnt = 0;
    budget   = 0;
    tail     = -1;
    while (budget < 200 && tail != 0) begin
      @(negedge clk_i);
      flush_i = 1'b0;
      budget++;
      if (flush_done_o) begin
        done_cnt++;
        if (tail < 0) tail = 4;
      end else if (done_cnt == 0 && lookup_ready_o) begin
        lr_bad++;
      end
      if (tail > 0) tail--;
      wb_ready_i = 1'b0;
      if (wb_valid_o) begin
        if (wait_cnt >= 3) begin
          wb_ready_i = 1'b1;
          wb_addrs.push_back(wb_addr_o);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    wb_ready_i = 1'b0;
    a0 = (wb_addrs.size() > 0) ? wb_addrs[0] : 32'hFFFF_FFFF;
    a1 = (wb_addrs.size() > 1) ? wb_addrs[1] : 32'hFFFF_FFFF;
    check("flush completes in budget", tail, 0);
    check("flush wb count", wb_addrs.size(), 2);
    check("flush wb 0 addr", a0, 'h1100);
    check("flush wb 1 addr", a1, 'h1300);
    check("flush done pulses", done_cnt, 1);
    check("flush lookup_ready low", lr_bad, 0);
    check("flush occupancy", occupancy_o, 0);
    check("flush no_wb", no_wb_o, 2);
    check("flush lookup_ready after", lookup_ready_o, 1);

    // Reset asserted while a flush writeback is pending.
    ins('h1500, 1);
    ins('h1600, 0);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    for (int k = 0; k < 10 && !wb_valid_o; k++) @(negedge clk_i);
    check("rst-wb reached writeback", wb_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    check("rst-wb wb_valid", wb_valid_o, 0);
    check("rst-wb occupancy", occupancy_o, 0);
    check("rst-wb lookup_ready", lookup_ready_o, 1);
    check("rst-wb evict_ready", evict_ready_o, 1);
    check("rst-wb rsp_valid", rsp_valid_o, 0);
    check("rst-wb flush_done", flush_done_o, 0);
    check("rst-wb no_acc", no_acc_o, 0);
    check("rst-wb no_wb", no_wb_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    lookup_miss('h1500, "post-rst 0x1500");
    lookup_miss('h1600, "post-rst 0x1600");
    lookup_miss('h400, "post-rst 0x400");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vc_assoc_controller.md
Name: vc_assoc_controller

Overview:
- Parametrised fully-associative victim cache controller with internal tag/data storage, sitting between the L1 data cache and the next memory level.
- Accepts L1 evictions, answers L1-miss lookups with a one-cycle registered response, and swaps lines when a hit and an eviction coincide.
- Writes back dirty displaced lines through a one-entry buffer, supports a full flush, and keeps access/hit/miss/writeback counters.

Parameters:
- ENTRIES, 4, number of fully-associative lines (power of 2, ≥2).
- ADDR_W, 32, byte address width.
- OFFSET_W, 4, line offset bits; tag = addr[ADDR_W-1:OFFSET_W].
- LINE_W, 128, line data width.
- CNT_W, 32, statistics counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- lookup_valid_i  in  1  L1 miss lookup request
- lookup_addr_i  in  ADDR_W  lookup address
- lookup_ready_o  out  1  lookup accepted when valid&ready
- rsp_valid_o  out  1  lookup response, one cycle after acceptance
- rsp_hit_o  out  1  response is a hit
- rsp_data_o  out  LINE_W  hit line data (0 on miss)
- rsp_dirty_o  out  1  hit line dirty bit
- evict_valid_i  in  1  L1 victim insert request
- evict_addr_i  in  ADDR_W  victim address
- evict_data_i  in  LINE_W  victim data
- evict_dirty_i  in  1  victim dirty
- evict_ready_o  out  1  insert accepted when valid&ready
- wb_valid_o  out  1  writeback buffer holds a line
- wb_addr_o  out  ADDR_W  writeback line address (offset bits 0)
- wb_data_o  out  LINE_W  writeback data
- wb_ready_i  in  1  memory accepts writeback
- flush_i  in  1  start flush pulse
- flush_done_o  out  1  one-cycle pulse at flush completion
- occupancy_o  out  $clog2(ENTRIES)+1  number of valid entries
- no_acc_o, no_hit_o, no_miss_o, no_wb_o  out  CNT_W each  statistics

Behaviour:
- Reset: all entries invalid; round-robin pointer 0; state RUN; all outputs 0 except lookup_ready_o=1, evict_ready_o=1.
- Lookup: accepted at edge t; parallel compare against all valid tags in the pre-update state; the response registers are loaded at edge t and are visible from t until the next edge (one cycle). On a hit the entry is invalidated (exclusive with L1). On a miss rsp_data_o=0.
- Insert: accepted when evict_valid_i && evict_ready_o. Target slot priority:
  - (1) the slot hit by a lookup accepted in the same cycle (swap; no writeback);
  - (2) an existing valid slot with the same tag (overwrite; dirty = old|new);
  - (3) the lowest-index invalid slot;
  - (4) the slot at the round-robin pointer, which then increments modulo ENTRIES.
  - A displaced valid dirty line is moved into the writeback buffer. A displaced clean line is dropped.
- evict_ready_o = (state==RUN) && !wb_valid_o. A conservative stall is acceptable.
- Writeback buffer: wb_valid_o is held with stable addr/data until wb_ready_i is sampled high. no_wb_o increments on each handshake.
- lookup_ready_o = (state==RUN). Lookups are not accepted during a flush.
- FSM:
  - RUN: on flush_i go to FL_SCAN. flush_i is ignored outside RUN.
  - FL_SCAN: index i from 0. A valid dirty entry is moved to the buffer when it is empty, the entry is invalidated, then go to FL_WB. A valid clean entry is invalidated. Otherwise i++. After i=ENTRIES-1 is processed with the buffer empty, go to RUN and pulse flush_done_o.
  - FL_WB: wait for the handshake, then return to FL_SCAN with i+1.
- Counters:
  - no_acc_o +1 per accepted lookup; no_hit_o / no_miss_o +1 at response; no_wb_o +1 per writeback handshake.
  - Counters wrap modulo 2^CNT_W. Invariant: acc = hit + miss once responses settle.
- Reset mid-flush or mid-writeback: all state is cleared immediately and the buffered line is lost (documented).
- occupancy_o is registered and updated the same edge as the storage.

Decomposition:
- Shared package cache_def gains:
  - vc_assoc_entry_type {valid, dirty, tag, data};
  - vc_lookup_rsp_type;
  - vc_wb_req_type;
  - the FSM enum vc_flush_state_type.
- Sub-module vc_rr_victim_sel: free-slot priority encoder plus round-robin pointer; outputs a slot index and a need_replace flag.
- Counters reuse adder_32bit when CNT_W=32.

Test Plan:
- Insert 0x1000 clean, then look up 0x1008 → rsp_valid_o high the next cycle, rsp_hit_o=1, data matches, occupancy 1→0; then look up 0x1000 again → miss, no_miss_o=1.
- Insert four dirty lines 0x100,0x200,0x300,0x400, then insert 0x500 → 0x100 appears on wb_valid_o; evict_ready_o=0 until wb_ready_i; no_wb_o=1; pointer=1.
- Same-cycle lookup hit on 0x200 plus insert 0x600 dirty → hit response for 0x200, 0x600 occupies the same slot, no writeback, occupancy unchanged.
- Insert 0x700 clean, then 0x700 dirty → single entry, dirty=1, occupancy +1 only.
- Fill with 2 dirty and 2 clean lines, pulse flush_i, hold wb_ready_i low for 3 cycles per line → exactly 2 writebacks in index order, lookup_ready_o=0 throughout, flush_done_o pulses once, occupancy 0.
- Assert rst_i during FL_WB → all outputs at reset values asynchronously; after release a lookup of any prior address misses.
